// File: rtl/keypad_reader.sv
// 4x4 matrix keypad scanner with press/release debounce; accepted hex keys shift
// into a 32-bit value (newest nibble in [3:0]) readable over the IO read path.
module keypad_reader #(
    parameter int SCAN_PERIOD    = 40000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    input  logic        IORead,
    input  logic        clear,
    output logic [31:0] read_data,
    output logic [31:0] out_num,
    output logic [3:0]  digit_cnt,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_pending
);
    localparam int PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_PERIOD - 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, ACCEPT, RELEASE} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [1:0]    col_idx;
    logic [3:0]    row_cap;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          single_row;
    logic [3:0]    row_low;
    logic [1:0]    row_idx;
    logic [3:0]    code;

    assign tick       = (presc == PRESC_MAX);
    assign row_low    = ~row_in;
    // Exactly one row low: non-zero and a power of two; ghosting/chords count as no key.
    assign single_row = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
    assign col_out    = ~(4'b0001 << col_idx);
    assign read_data  = IORead ? out_num : 32'h0;
    assign code       = {row_idx, col_idx};

    always_comb begin
        row_idx = 2'd0;
        case (~row_cap)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= SCAN;
            presc       <= '0;
            col_idx     <= 2'd0;
            row_cap     <= 4'hF;
            cnt         <= '0;
            out_num     <= 32'h0;
            digit_cnt   <= 4'd0;
            key_valid   <= 1'b0;
            key_code    <= 4'd0;
            key_pending <= 1'b0;
        end else begin
            presc     <= tick ? '0 : presc + 1'b1;
            key_valid <= 1'b0;
            if (IORead) key_pending <= 1'b0;
            if (clear) begin
                out_num   <= 32'h0;
                digit_cnt <= 4'd0;
            end
            case (state)
                SCAN: if (tick) begin
                    if (single_row) begin
                        row_cap   <= row_in;
                        cnt       <= CW'(1);
                        state     <= (DEBOUNCE_SCANS == 1) ? ACCEPT : DEBOUNCE;
                        key_valid <= (DEBOUNCE_SCANS == 1);
                    end else begin
                        col_idx <= col_idx + 2'd1;
                    end
                end
                DEBOUNCE: if (tick) begin
                    if (row_in == row_cap) begin
                        cnt <= cnt + 1'b1;
                        if (cnt + 1'b1 == CNT_DONE) begin
                            state     <= ACCEPT;
                            key_valid <= 1'b1;
                        end
                    end else begin
                        state   <= SCAN;
                        col_idx <= col_idx + 2'd1;
                    end
                end
                ACCEPT: begin
                    // key_pending set here overrides a coincident IORead clear above.
                    key_code    <= code;
                    key_pending <= 1'b1;
                    if (!clear) begin
                        out_num   <= {out_num[27:0], code};
                        digit_cnt <= (digit_cnt == 4'd8) ? 4'd8 : digit_cnt + 4'd1;
                    end
                    cnt   <= '0;
                    state <= RELEASE;
                end
                RELEASE: if (tick) begin
                    if (row_in == 4'hF) begin
                        if (cnt + 1'b1 == CNT_DONE) begin
                            cnt     <= '0;
                            state   <= SCAN;
                            col_idx <= col_idx + 2'd1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_reader.sv
// Self-checking bench for keypad_reader: behavioural keypad matrix plus a digit-queue
// model of the accumulated value, with directed and randomized key sequences.
module tb_keypad_reader;
    localparam int SP = 4;
    localparam int DS = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        IORead = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  row_in, col_out, digit_cnt, key_code;
    logic [31:0] read_data, out_num;
    logic        key_valid, key_pending;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic prev_kv = 1'b0;
    logic [3:0] press_rows [4];
    int unsigned digits [$];

    keypad_reader #(.SCAN_PERIOD(SP), .DEBOUNCE_SCANS(DS)) dut (
        .clock(clock), .reset(reset), .row_in(row_in), .col_out(col_out),
        .IORead(IORead), .clear(clear), .read_data(read_data), .out_num(out_num),
        .digit_cnt(digit_cnt), .key_valid(key_valid), .key_code(key_code),
        .key_pending(key_pending)
    );

    always #5 clock = ~clock;

    // Passive matrix: a driven (low) column pulls low whichever rows are pressed on it.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!col_out[c]) row_in = row_in & ~press_rows[c];
    end

    // Pulse monitor, sampled just after the edge so tasks reading at negedge see a settled count.
    always @(posedge clock) begin
        #1;
        if (key_valid) begin
            pulses++;
            checks++;
            if (prev_kv) begin
                errors++;
                $display("FAIL kv_width: key_valid high %0d consecutive cycles, required 1", 2);
            end
        end
        prev_kv = key_valid;
    end

    function automatic logic [31:0] model_num();
        logic [31:0] v = 32'h0;
        foreach (digits[i]) v = (v << 4) | 32'(digits[i] & 32'hF);
        return v;
    endfunction

    function automatic logic [3:0] model_cnt();
        return 4'(digits.size());
    endfunction

    task automatic model_push(input logic [3:0] code);
        digits.push_back(32'(code));
        if (digits.size() > 8) void'(digits.pop_front());
    endtask

    task automatic release_all();
        for (int c = 0; c < 4; c++) press_rows[c] = 4'h0;
    endtask

    task automatic do_reset();
        release_all();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        digits.delete();
    endtask

    task automatic press(input logic [3:0] code);
        press_rows[code[1:0]] = 4'b0001 << code[3:2];
    endtask

    task automatic wait_col(input logic [3:0] pattern);
        int n = 0;
        while (col_out !== pattern && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (col_out !== pattern) begin
            errors++;
            $display("FAIL wait_col: col_out=%b, required %b within 200 cycles", col_out, pattern);
        end
    endtask

    // Press a key until accepted; optionally assert clear/IORead in the accept cycle.
    task automatic press_key(input logic [3:0] code, input bit do_clear, input bit do_read,
                             output bit got);
        got = 1'b0;
        press(code);
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clock);
            if (key_valid) begin
                got    = 1'b1;
                clear  = do_clear;
                IORead = do_read;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL press_timeout: code=%h key_valid=0, required a pulse within 400 cycles", code);
        end
        @(negedge clock);
        clear  = 1'b0;
        IORead = 1'b0;
        release_all();
        repeat (SP * (DS + 3)) @(negedge clock);
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (col_out !== 4'b1110) begin errors++; $display("FAIL rst_col: col_out=%b, required 1110", col_out); end
        if (out_num !== 32'h0) begin errors++; $display("FAIL rst_num: out_num=%h, required 0", out_num); end
        if (digit_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt: digit_cnt=%0d, required 0", digit_cnt); end
        if (key_valid !== 1'b0 || key_code !== 4'd0) begin
            errors++; $display("FAIL rst_key: key_valid=%b key_code=%h, required 0/0", key_valid, key_code);
        end
        if (key_pending !== 1'b0) begin errors++; $display("FAIL rst_pend: key_pending=%b, required 0", key_pending); end
        if (read_data !== 32'h0) begin errors++; $display("FAIL rst_rd: read_data=%h, required 0", read_data); end
    endtask

    task automatic test_scan();
        int p0;
        logic [3:0] exp_col;
        do_reset();
        p0 = pulses;
        for (int k = 0; k < 40; k++) begin
            exp_col = ~(4'b0001 << ((k / SP) % 4));
            checks++;
            if (col_out !== exp_col) begin
                errors++; $display("FAIL scan_col: cycle %0d col_out=%b, required %b", k, col_out, exp_col);
            end
            @(negedge clock);
        end
        checks++;
        if (pulses != p0) begin errors++; $display("FAIL scan_kv: %0d pulses with no key, required 0", pulses - p0); end
    endtask

    task automatic test_single();
        int p0, t;
        do_reset();
        p0 = pulses;
        press(4'h6);
        wait_col(4'b1011);
        t = 0;
        while (!key_valid && t < 100) begin @(negedge clock); t++; end
        checks++;
        if (t != SP * DS) begin errors++; $display("FAIL single_lat: accept after %0d cycles, required %0d", t, SP * DS); end
        release_all();
        t = 0;
        while (col_out === 4'b1011 && t < 100) begin @(negedge clock); t++; end
        checks++;
        if (t != SP * DS) begin errors++; $display("FAIL single_rel: scan resumed after %0d cycles, required %0d", t, SP * DS); end
        model_push(4'h6);
        repeat (4) @(negedge clock);
        checks += 4;
        if (pulses - p0 != 1) begin errors++; $display("FAIL single_cnt: %0d pulses, required 1", pulses - p0); end
        if (key_code !== 4'h6) begin errors++; $display("FAIL single_code: key_code=%h, required 6", key_code); end
        if (out_num !== model_num()) begin errors++; $display("FAIL single_num: out_num=%h, required %h", out_num, model_num()); end
        if (digit_cnt !== model_cnt() || key_pending !== 1'b1) begin
            errors++; $display("FAIL single_dc: digit_cnt=%0d pend=%b, required %0d/1", digit_cnt, key_pending, model_cnt());
        end
    endtask

    task automatic test_bounce();
        int p0, t;
        do_reset();
        p0 = pulses;
        wait_col(4'b1101);
        press(4'h9);
        repeat (2 * SP) @(negedge clock);
        release_all();
        repeat (SP) @(negedge clock);
        press(4'h9);
        t = 0;
        while (!key_valid && t < 200) begin @(negedge clock); t++; end
        // Release, then a one-tick bounce back low must restart the release count.
        release_all();
        repeat (SP) @(negedge clock);
        press(4'h9);
        repeat (SP) @(negedge clock);
        release_all();
        t = 0;
        while (col_out === 4'b1101 && t < 100) begin @(negedge clock); t++; end
        checks++;
        if (t != SP * DS) begin errors++; $display("FAIL bounce_rel: scan resumed after %0d cycles, required %0d", t, SP * DS); end
        model_push(4'h9);
        repeat (4) @(negedge clock);
        checks += 3;
        if (pulses - p0 != 1) begin errors++; $display("FAIL bounce_cnt: %0d pulses, required 1", pulses - p0); end
        if (key_code !== 4'h9) begin errors++; $display("FAIL bounce_code: key_code=%h, required 9", key_code); end
        if (out_num !== model_num()) begin errors++; $display("FAIL bounce_num: out_num=%h, required %h", out_num, model_num()); end
    endtask

    task automatic test_nine();
        bit got;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            press_key(4'(k), 1'b0, 1'b0, got);
            if (got) model_push(4'(k));
        end
        checks += 2;
        if (out_num !== model_num()) begin errors++; $display("FAIL nine_num: out_num=%h, required %h", out_num, model_num()); end
        if (digit_cnt !== model_cnt()) begin errors++; $display("FAIL nine_cnt: digit_cnt=%0d, required %0d", digit_cnt, model_cnt()); end
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        digits.delete();
        checks++;
        if (out_num !== 32'h0 || digit_cnt !== 4'd0) begin
            errors++; $display("FAIL nine_clr: out_num=%h digit_cnt=%0d, required 0/0", out_num, digit_cnt);
        end
    endtask

    task automatic test_two_rows();
        int p0 = pulses;
        press_rows[3] = 4'b0101;
        repeat (30 * SP) @(negedge clock);
        release_all();
        repeat (2 * SP) @(negedge clock);
        checks++;
        if (pulses != p0) begin errors++; $display("FAIL two_rows: %0d pulses, required 0", pulses - p0); end
    endtask

    task automatic test_clear_accept();
        bit got;
        press_key(4'hA, 1'b0, 1'b0, got);
        if (got) model_push(4'hA);
        press_key(4'h5, 1'b1, 1'b1, got);
        digits.delete();
        checks += 3;
        if (out_num !== model_num() || digit_cnt !== model_cnt()) begin
            errors++; $display("FAIL clr_acc_num: out_num=%h digit_cnt=%0d, required 0/0", out_num, digit_cnt);
        end
        if (key_code !== 4'h5) begin errors++; $display("FAIL clr_acc_code: key_code=%h, required 5", key_code); end
        if (key_pending !== 1'b1) begin errors++; $display("FAIL clr_acc_pend: key_pending=%b, required 1", key_pending); end
    endtask

    task automatic test_pending();
        bit got;
        press_key(4'hC, 1'b0, 1'b0, got);
        if (got) model_push(4'hC);
        IORead = 1'b1;
        #1;
        checks += 2;
        if (read_data !== model_num()) begin errors++; $display("FAIL rd_data: read_data=%h, required %h", read_data, model_num()); end
        if (key_pending !== 1'b1) begin errors++; $display("FAIL pend_set: key_pending=%b, required 1", key_pending); end
        @(negedge clock);
        IORead = 1'b0;
        #1;
        checks += 2;
        if (key_pending !== 1'b0) begin errors++; $display("FAIL pend_clr: key_pending=%b, required 0", key_pending); end
        if (read_data !== 32'h0) begin errors++; $display("FAIL rd_idle: read_data=%h, required 0", read_data); end
    endtask

    task automatic test_random();
        bit got;
        logic [3:0] code;
        for (int n = 0; n < 10; n++) begin
            code = 4'($urandom_range(0, 15));
            press_key(code, 1'b0, 1'b0, got);
            if (got) model_push(code);
            checks += 3;
            if (out_num !== model_num()) begin errors++; $display("FAIL rand_num: out_num=%h, required %h", out_num, model_num()); end
            if (digit_cnt !== model_cnt()) begin errors++; $display("FAIL rand_cnt: digit_cnt=%0d, required %0d", digit_cnt, model_cnt()); end
            if (key_code !== code) begin errors++; $display("FAIL rand_code: key_code=%h, required %h", key_code, code); end
        end
    endtask

    task automatic test_reset_mid();
        press(4'h7);
        wait_col(4'b0111);
        repeat (SP + 2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        release_all();
        checks += 4;
        if (col_out !== 4'b1110) begin errors++; $display("FAIL mid_col: col_out=%b, required 1110", col_out); end
        if (out_num !== 32'h0 || digit_cnt !== 4'd0) begin
            errors++; $display("FAIL mid_num: out_num=%h digit_cnt=%0d, required 0/0", out_num, digit_cnt);
        end
        if (key_code !== 4'd0 || key_valid !== 1'b0) begin
            errors++; $display("FAIL mid_key: key_code=%h key_valid=%b, required 0/0", key_code, key_valid);
        end
        if (key_pending !== 1'b0) begin errors++; $display("FAIL mid_pend: key_pending=%b, required 0", key_pending); end
        reset = 1'b0;
        digits.delete();
    endtask

    initial begin
        release_all();
        test_reset();
        test_scan();
        test_single();
        test_bounce();
        test_nine();
        test_two_rows();
        test_clear_accept();
        test_pending();
        test_random();
        test_reset_mid();
        repeat (4) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
